// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: pops one 24-bit pixel per active clock from a normal
// (non-show-ahead) FIFO and drives registered RGB/sync/blank two clocks later.
module vga_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned START_LEVEL = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] fifo_q,
  input  logic        rdempty,
  input  logic [9:0]  rdusedw,
  output logic        rdreq,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start,
  output logic        underflow
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] FILL     = 10'(START_LEVEL);

  typedef enum logic {WAIT_FILL, RUN} state_t;

  state_t     state;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  logic run, active, hs_c, vs_c, fs_c;
  logic active_d, rd_d, hs_d, vs_d, fs_d;

  // Stage 0: everything is forced to its idle level until the raster runs.
  always_comb begin
    run    = (state == RUN);
    active = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    rdreq  = active && !rdempty;
    hs_c   = !(run && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_c   = !(run && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    fs_c   = run && (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= WAIT_FILL;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        WAIT_FILL: begin
          if (rdusedw >= FILL) state <= RUN;
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
        end
      endcase
    end
  end

  // Stage 1 lines up with the FIFO read latency; stage 2 registers the pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_d    <= 1'b0;
      rd_d        <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      fs_d        <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      underflow   <= 1'b0;
    end else begin
      active_d    <= active;
      rd_d        <= rdreq;
      hs_d        <= hs_c;
      vs_d        <= vs_c;
      fs_d        <= fs_c;
      hsync       <= hs_d;
      vsync       <= vs_d;
      blank_n     <= active_d;
      frame_start <= fs_d && active_d;
      {vga_r, vga_g, vga_b} <= rd_d ? fifo_q : '0;
      underflow   <= underflow | (active && rdempty);
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (25x15 clocks per frame)
// so whole frames, underflow and mid-frame reset fit in a short run.
module tb_vga_scanout;

  // Raster: H 16/2/4/3 -> 25 clocks, hsync low h=18..21; V 8/2/2/3 -> 15 lines, vsync low v=10..11.
  localparam int unsigned HA = 16;
  localparam int unsigned VA = 8;
  localparam int unsigned HT = 25;
  localparam int unsigned VT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] fifo_q = '0;
  logic        rdempty = 1'b0;
  logic [9:0]  rdusedw = '0;
  logic        rdreq;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, blank_n, frame_start, underflow;

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .START_LEVEL(256)
  ) dut (
    .clock(clock), .reset(reset), .fifo_q(fifo_q), .rdempty(rdempty),
    .rdusedw(rdusedw), .rdreq(rdreq), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // FIFO holding 1, 2, 3, ... ; data appears the cycle after rdreq.
  always @(posedge clock) if (rdreq) fifo_q <= fifo_q + 24'd1;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned pos_h, pos_v;
  exp_t        pipe1, pipe2;
  logic [23:0] exp_word = '0;
  logic        uf_exp;
  int          rd_cnt, frame_idx, fs_gap;
  logic        fs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdreq"},     rdreq,       0);
    check({tag, "_rgb"},       {vga_r, vga_g, vga_b}, 0);
    check({tag, "_hsync"},     hsync,       1);
    check({tag, "_vsync"},     vsync,       1);
    check({tag, "_blank_n"},   blank_n,     0);
    check({tag, "_frame_st"},  frame_start, 0);
    check({tag, "_underflow"}, underflow,   0);
  endtask

  task automatic init_run();
    pos_h     = 0;
    pos_v     = 0;
    pipe1     = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, rgb: 24'h0};
    pipe2     = pipe1;
    uf_exp    = 1'b0;
    rd_cnt    = 0;
    frame_idx = 0;
    fs_gap    = 0;
    fs_seen   = 1'b0;
  endtask

  // One raster clock: outputs must show the position from two clocks ago,
  // rdreq must reflect the current position and the driven rdempty.
  task automatic step(input logic empty_val);
    logic act, erd;
    exp_t e;
    @(negedge clock);
    check("hsync",       hsync,       pipe2.hs);
    check("vsync",       vsync,       pipe2.vs);
    check("blank_n",     blank_n,     pipe2.bl);
    check("frame_start", frame_start, pipe2.fs);
    check("rgb",         {vga_r, vga_g, vga_b}, pipe2.rgb);
    check("underflow",   underflow,   uf_exp);
    if (frame_start) begin
      if (fs_seen) check("fs_period", fs_gap, HT * VT);
      fs_seen = 1'b1;
      fs_gap  = 1;
    end else begin
      fs_gap++;
    end
    if (pos_h == 0 && pos_v == 0) begin
      if (frame_idx > 0) check("rd_per_frame", rd_cnt, (frame_idx == 2) ? 123 : 128);
      rd_cnt = 0;
      frame_idx++;
    end
    rdempty = empty_val;
    #1;
    act = (pos_h < HA) && (pos_v < VA);
    erd = act && !empty_val;
    check("rdreq", rdreq, erd);
    if (rdreq) rd_cnt++;
    e.hs = !(pos_h >= 18 && pos_h <= 21);
    e.vs = !(pos_v >= 10 && pos_v <= 11);
    e.bl = act;
    e.fs = (pos_h == 0 && pos_v == 0);
    if (erd) exp_word = exp_word + 24'd1;
    e.rgb = erd ? exp_word : 24'h0;
    uf_exp = uf_exp | (act && empty_val);
    pipe2 = pipe1;
    pipe1 = e;
    if (pos_h == HT - 1) begin
      pos_h = 0;
      pos_v = (pos_v == VT - 1) ? 0 : pos_v + 1;
    end else begin
      pos_h++;
    end
  endtask

  initial begin
    reset   = 1'b0;
    rdusedw = 10'd300;
    rdempty = 1'b0;
    init_run();
    repeat (3) begin
      @(negedge clock);
      check_idle("rst");
    end

    // Primed FIFO: raster starts on the first edge after release.
    reset = 1'b1;
    // Two frames plus part of a third; frame 1 starves at line 3, h=5..9.
    for (int i = 0; i < 2 * HT * VT + 5 * HT + 7; i++)
      step(frame_idx == 2 && pos_v == 3 && pos_h >= 5 && pos_h <= 9);

    // Asynchronous mid-frame reset, away from any clock edge.
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(negedge clock);
    rdusedw = 10'd100;
    reset   = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check_idle("wait100");
    end
    rdusedw = 10'd255;
    repeat (20) begin
      @(negedge clock);
      check_idle("wait255");
    end

    rdusedw = 10'd256;
    init_run();
    for (int i = 0; i < HT * VT + 2; i++) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the pixel FIFO that the tile-upscaling writer fills.
- Generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Pops one 24-bit pixel per active-region clock and drives registered RGB, sync and blank outputs to the DAC/connector.
- Holds off the raster until the FIFO is primed, and flags any underflow.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- START_LEVEL, 256, FIFO fill (rdusedw) required before the raster starts

Ports:
- clock  in  1  pixel clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fifo_q  in  24  FIFO read data, {R[23:16],G[15:8],B[7:0]}, valid the cycle after rdreq (normal, non-show-ahead FIFO)
- rdempty  in  1  FIFO empty
- rdusedw  in  10  FIFO fill level
- rdreq  out  1  FIFO read request
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  high during the visible region
- frame_start  out  1  one-clock pulse aligned with the first visible pixel of each frame
- underflow  out  1  sticky, set on any starved active pixel

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters: h_cnt[9:0] and v_cnt[9:0].
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps, and wraps V_TOTAL-1 -> 0.
- Reset (reset low, async):
  - state = WAIT_FILL; h_cnt = v_cnt = 0; all pipeline registers cleared.
  - Outputs: rdreq = 0, rgb = 0, hsync = 1, vsync = 1, blank_n = 0, frame_start = 0, underflow = 0.
- FSM:
  - WAIT_FILL: counters held at 0; rdreq = 0; outputs stay at reset values. Go to RUN when rdusedw >= START_LEVEL.
  - RUN: counters free-run. Never leaves RUN except via reset. An underflow does not restart the frame.
- Stage 0 (combinational from counters, RUN only):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - rdreq = active && !rdempty.
- Stage 1 (registered) captures from stage 0:
  - active_d
  - rd_d = rdreq
  - hs_d = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for 656..751
  - vs_d = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for lines 490..491
  - fs_d = (h_cnt == 0 && v_cnt == 0)
- Stage 2 (registered outputs):
  - hsync = hs_d; vsync = vs_d; blank_n = active_d; frame_start = fs_d && active_d.
  - {vga_r,vga_g,vga_b} = rd_d ? fifo_q : 24'h0.
- Latency: every output reflects counter position (h,v) exactly 2 clocks after the counters held (h,v). All outputs stay mutually aligned.
- Underflow: if active && rdempty in RUN, rdreq stays 0 and that pixel outputs black.
  - underflow is set on the next clock and remains set until reset.
  - The raster position keeps advancing; subsequent pixels resume from the FIFO as soon as rdempty deasserts.
- Blanking region: rdreq is never asserted, even if the FIFO is non-empty. RGB is forced to 0 whenever blank_n = 0.
- Exactly H_ACTIVE*V_ACTIVE = 307200 reads per frame when no underflow occurs.
- Reset mid-frame: everything returns to WAIT_FILL immediately. Re-priming is required; the FIFO contents are not flushed by this block.

Test Plan:
- Reset low, rdusedw = 300 held -> all outputs at reset values while reset low. One clock after release, rdreq rises. Outputs after 2 more clocks: blank_n = 1, frame_start = 1 for one clock, rgb = first FIFO word.
- rdusedw = 100, stays below 256 -> rdreq = 0, hsync = vsync = 1, blank_n = 0 indefinitely. Raising rdusedw to 256 -> RUN begins on the next clock.
- FIFO model never empty, one full frame -> 307200 rdreq pulses.
  - 640 per line, none in h 640..799 or v 480..524.
  - hsync low for 96 clocks starting 656 clocks after each line start.
  - vsync low for exactly 2 lines (1600 clocks) starting at line 490.
  - frame period 420000 clocks.
- Feed incrementing data 0x000001, 0x000002, ... -> pixel at (h,v) equals v*640+h+1 on outputs, 2 clocks after the counters reach (h,v).
- Force rdempty = 1 for 5 clocks mid-line 10 -> those 5 pixels are 0x000000, underflow sets and stays 1. Later pixels resume from the FIFO without losing sync, and hsync/vsync timing is unchanged.
- Assert reset at line 200, h = 300 -> outputs return to reset values asynchronously, underflow clears, WAIT_FILL re-entered. The next frame starts from (0,0) with frame_start.
